otf_quotient_converter: RTL

On-the-fly converter that consumes the serial signed-digit quotient stream of the online divider, one digit per cycle, MSD first, each digit in plus/minus bit encoding. It keeps the two conventional registers Q and QM, with no carry-propagate adder on the digit path. After DIGITS digits it presents the quotient as a two's-complement word. It sits at the output end of the divider, after digit selection.

---
 rtl/otf_pkg.sv | 35 +++
 rtl/otf_quotient_converter_shift_pair.sv | 66 ++++++
 rtl/otf_quotient_converter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/otf_pkg.sv
// Shared definitions for the on-the-fly quotient converter.
// Holds the FSM state encoding, the signed-digit payload and decode constants,
// and the digit-count derivation. OTF_ROUND_EN adds one guard digit that is
// consumed by the final round-half-up step.
package otf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // One signed quotient digit in plus/minus bit encoding.
  typedef struct packed {
    logic plus;
    logic minus;
  } sd_digit_t;

  // {plus, minus} codes; 2'b11 also decodes to zero.
  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_NEG  = 2'b01;

`ifdef OTF_ROUND_EN
  localparam int unsigned ROUND_EXTRA = 1;
`else
  localparam int unsigned ROUND_EXTRA = 0;
`endif

  // Digits accepted per conversion (LAST).
  function automatic int unsigned last_count(input int unsigned digits);
    return digits + ROUND_EXTRA;
  endfunction

endpackage

// File: rtl/otf_quotient_converter_shift_pair.sv
// otf_shift_pair: the Q / QM register pair of the on-the-fly conversion.
// Each step shifts one signed digit in as the new LSB, selecting the source
// register so that QM = Q - 1 is preserved and no carry chain is needed.
// Ports:
//   clk, asyn_reset  clock and synchronous active-high reset
//   init             load Q = 0, QM = -1
//   step             shift in digit (ignored when init is high)
//   digit            signed digit, plus/minus encoding
//   q_next_c         value Q takes at the next edge (combinational)
module otf_shift_pair
  import otf_pkg::*;
#(
  parameter int unsigned W = 65
) (
  input  logic         clk,
  input  logic         asyn_reset,
  input  logic         init,
  input  logic         step,
  input  sd_digit_t    digit,
  output logic [W-1:0] q_next_c
);

  logic [W-1:0] q;
  logic [W-1:0] qm;
  logic [W-1:0] q_nxt;
  logic [W-1:0] qm_nxt;

  // Digit update rule; the MSB falls off, width stays fixed.
  always_comb begin
    q_nxt  = q;
    qm_nxt = qm;
    if (init) begin
      q_nxt  = '0;
      qm_nxt = '1;
    end else if (step) begin
      case ({digit.plus, digit.minus})
        DIG_POS: begin
          q_nxt  = {q[W-2:0], 1'b1};
          qm_nxt = {q[W-2:0], 1'b0};
        end
        DIG_NEG: begin
          q_nxt  = {qm[W-2:0], 1'b1};
          qm_nxt = {qm[W-2:0], 1'b0};
        end
        default: begin
          q_nxt  = {q[W-2:0], 1'b0};
          qm_nxt = {qm[W-2:0], 1'b1};
        end
      endcase
    end
  end

  // Register pair.
  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      q  <= '0;
      qm <= '1;
    end else begin
      q  <= q_nxt;
      qm <= qm_nxt;
    end
  end

  assign q_next_c = q_nxt;

endmodule

// File: rtl/otf_quotient_converter.sv
// otf_quotient_converter: turns the MSD-first signed-digit quotient stream of
// the online divider into a two's-complement word using on-the-fly conversion.
// Optional macro OTF_ROUND_EN: accept one extra digit and round half up, with
// saturation on positive overflow; otherwise the result is truncated.
// Ports:
//   clk, asyn_reset        clock and synchronous active-high reset
//   enable                 global stall; low freezes all state
//   start                  begin (or restart) a conversion
//   digit_valid            q_plus / q_minus carry a digit
//   q_plus, q_minus        signed digit bits
//   digit_ready            digit accepted this cycle if valid (comb.)
//   quotient               result, value = quotient * 2^-DIGITS
//   quotient_valid         one-cycle pulse with a new quotient
//   busy                   conversion in progress
module otf_quotient_converter
  import otf_pkg::*;
#(
  parameter int unsigned DIGITS    = 64,
  parameter int unsigned CNT_WIDTH = 7
) (
  input  logic              clk,
  input  logic              asyn_reset,
  input  logic              enable,
  input  logic              start,
  input  logic              digit_valid,
  input  logic              q_plus,
  input  logic              q_minus,
  output logic              digit_ready,
  output logic [DIGITS:0]   quotient,
  output logic              quotient_valid,
  output logic              busy
);

  localparam int unsigned LAST = last_count(DIGITS);
  localparam int unsigned QW   = LAST + 1;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 init_c;
  logic                 step_c;
  logic                 load_c;
  logic                 accept_c;
  logic [QW-1:0]        q_next_c;
  logic [DIGITS:0]      result_c;
  sd_digit_t            digit_c;

  assign digit_c     = '{plus: q_plus, minus: q_minus};
  // Depends only on state and enable, never on digit_valid.
  assign digit_ready = enable && (state_q == ST_CONVERT);
  assign accept_c    = digit_ready && digit_valid;

  // Next-state, counter and datapath controls; start overrides any digit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_c  = 1'b0;
    step_c  = 1'b0;
    load_c  = 1'b0;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_CONVERT;
            cnt_d   = '0;
            init_c  = 1'b1;
          end
        end
        ST_CONVERT: begin
          if (start) begin
            cnt_d  = '0;
            init_c = 1'b1;
          end else if (accept_c) begin
            step_c = 1'b1;
            cnt_d  = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(LAST - 1)) begin
              state_d = ST_DONE;
              load_c  = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            state_d = ST_CONVERT;
            cnt_d   = '0;
            init_c  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counter and registered outputs; enable low holds everything.
  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      quotient       <= '0;
      quotient_valid <= 1'b0;
      busy           <= 1'b0;
    end else if (enable) begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      quotient_valid <= (state_d == ST_DONE);
      busy           <= (state_d == ST_CONVERT);
      if (load_c) quotient <= result_c;
    end
  end

  otf_shift_pair #(.W(QW)) u_pair (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .init       (init_c),
    .step       (step_c),
    .digit      (digit_c),
    .q_next_c   (q_next_c)
  );

`ifdef OTF_ROUND_EN
  // (Q + 1) >>> 1; only Q = max positive overflows, and it saturates.
  logic [QW-1:0] rnd_sum_c;
  assign rnd_sum_c = q_next_c + QW'(1);
  assign result_c  = (q_next_c == {1'b0, {(QW-1){1'b1}}}) ?
                     {1'b0, {DIGITS{1'b1}}} : rnd_sum_c[QW-1:1];
`else
  assign result_c  = q_next_c;
`endif

endmodule
